// File: rtl/ramdma_ci_bidir.sv
// DMA custom instruction: dual-port local word memory plus a bidirectional burst bus master.
// Optional feature macro: RAMDMA_IRQ_EN adds a sticky irq output mirrored in status bit 2.
module ramdma_ci_bidir #(
    parameter logic [7:0] CUSTOM_ID  = 8'd14,
    parameter int         MEM_ADDR_W = 9,
    parameter int         BLOCK_W    = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    input  logic        granted,
    input  logic [31:0] address_data_in,
    input  logic        end_transaction_in,
    input  logic        data_valid_in,
    input  logic        busy_in,
    input  logic        error_in,
    output logic        request,
    output logic [31:0] address_data_out,
    output logic [3:0]  byte_enables_out,
    output logic [7:0]  burst_size_out,
    output logic        read_n_write_out,
    output logic        begin_transaction_out,
    output logic        end_transaction_out,
    output logic        data_valid_out
`ifdef RAMDMA_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int LEN_W = (BLOCK_W > 9) ? BLOCK_W : 9;
    localparam int DEPTH = 2 ** MEM_ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_BEGIN, S_RDATA, S_WFETCH, S_WDATA, S_WEND, S_NEXT
    } state_t;

    state_t state_q, state_d;

    logic [31:0]           mem [DEPTH];
    logic [31:0]           cpu_rdata_q, dma_rdata_q;
    logic                  rd_pend_q;
    logic [31:0]           bus_addr_q, bus_ptr_q;
    logic [MEM_ADDR_W-1:0] mem_start_q, mem_ptr_q, dma_rd_addr;
    logic [BLOCK_W-1:0]    block_q, remaining_q, rem_next;
    logic [7:0]            burst_q, burst_w_q;
    logic [LEN_W-1:0]      cnt_q, len, burst_len, rem_len;
    logic                  dir_rd_q, error_q, irq_bit;

    logic                  ci_hit, ci_wr, cpu_mem_wr, cpu_mem_rd, ctrl_wr, go, abort;
    logic                  rd_accept, wr_accept, last_word, dma_rd_en, finish;
    logic [2:0]            ci_sel;
    logic [MEM_ADDR_W-1:0] ci_addr;
    logic [31:0]           reg_rdata;
    logic                  unused_ok;

    assign ci_hit     = start && (ciN == CUSTOM_ID);
    assign ci_addr    = valueA[MEM_ADDR_W-1:0];
    assign ci_wr      = valueA[MEM_ADDR_W];
    assign ci_sel     = valueA[MEM_ADDR_W+3:MEM_ADDR_W+1];
    assign unused_ok  = ^valueA[31:MEM_ADDR_W+4];
    assign cpu_mem_wr = ci_hit && ci_wr && (ci_sel == 3'd0);
    assign cpu_mem_rd = ci_hit && !ci_wr && (ci_sel == 3'd0);
    assign ctrl_wr    = ci_hit && ci_wr && (ci_sel == 3'd5);
    assign go         = ctrl_wr && (valueB[0] || valueB[1]) && (state_q == S_IDLE) && (block_q != '0);
    assign abort      = error_in && (state_q != S_IDLE);

    // Burst length is the configured burst or whatever is left of the block, whichever is smaller.
    assign burst_len  = LEN_W'(burst_w_q) + LEN_W'(1);
    assign rem_len    = LEN_W'(remaining_q);
    assign len        = (burst_len < rem_len) ? burst_len : rem_len;
    assign rem_next   = remaining_q - BLOCK_W'(len);
    assign finish     = (state_q == S_NEXT) && (rem_next == '0) && !error_in;

    assign rd_accept  = (state_q == S_RDATA) && data_valid_in && !error_in;
    assign wr_accept  = (state_q == S_WDATA) && !busy_in && !error_in;
    assign last_word  = (cnt_q == len - LEN_W'(1));
    assign dma_rd_en  = (state_q == S_WFETCH) || wr_accept;
    assign dma_rd_addr = wr_accept ? mem_ptr_q + MEM_ADDR_W'(1) : mem_ptr_q;

    // NOTE: the memory and its read registers carry no reset so they can map onto block RAM.
    always_ff @(posedge clock) begin
        if (cpu_mem_wr) mem[ci_addr] <= valueB;
        if (rd_accept)  mem[mem_ptr_q] <= address_data_in;  // last write wins: DMA beats CPU
        if (cpu_mem_rd) cpu_rdata_q <= mem[ci_addr];
        if (dma_rd_en)  dma_rdata_q <= mem[dma_rd_addr];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (go) state_d = S_REQ;
                S_REQ:    if (granted) state_d = S_BEGIN;
                S_BEGIN:  state_d = dir_rd_q ? S_RDATA : S_WFETCH;
                S_RDATA:  if (end_transaction_in) state_d = S_NEXT;
                S_WFETCH: state_d = S_WDATA;
                S_WDATA:  if (wr_accept && last_word) state_d = S_WEND;
                S_WEND:   state_d = S_NEXT;
                S_NEXT:   state_d = (rem_next == '0) ? S_IDLE : S_REQ;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        request               = 1'b0;
        address_data_out      = '0;
        byte_enables_out      = '0;
        burst_size_out        = '0;
        read_n_write_out      = 1'b0;
        begin_transaction_out = 1'b0;
        end_transaction_out   = 1'b0;
        data_valid_out        = 1'b0;
        case (state_q)
            S_REQ: request = 1'b1;
            S_BEGIN: begin
                begin_transaction_out = 1'b1;
                address_data_out      = bus_ptr_q;
                byte_enables_out      = 4'hF;
                burst_size_out        = 8'(len - LEN_W'(1));
                read_n_write_out      = dir_rd_q;
            end
            S_WDATA: begin
                data_valid_out   = 1'b1;
                address_data_out = dma_rdata_q;
            end
            S_WEND:  end_transaction_out = !error_in;
            default: ;
        endcase
    end

    // Configuration registers and the working copies taken at start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus_addr_q  <= '0;
            mem_start_q <= '0;
            block_q     <= '0;
            burst_q     <= '0;
            bus_ptr_q   <= '0;
            mem_ptr_q   <= '0;
            remaining_q <= '0;
            burst_w_q   <= '0;
            cnt_q       <= '0;
            dir_rd_q    <= 1'b0;
            error_q     <= 1'b0;
            rd_pend_q   <= 1'b0;
        end else begin
            rd_pend_q <= cpu_mem_rd;
            if (ci_hit && ci_wr) begin
                case (ci_sel)
                    3'd1:    bus_addr_q  <= valueB;
                    3'd2:    mem_start_q <= valueB[MEM_ADDR_W-1:0];
                    3'd3:    block_q     <= valueB[BLOCK_W-1:0];
                    3'd4:    burst_q     <= valueB[7:0];
                    default: ;
                endcase
            end
            if (go) begin
                bus_ptr_q   <= bus_addr_q;
                mem_ptr_q   <= mem_start_q;
                remaining_q <= block_q;
                burst_w_q   <= burst_q;
                dir_rd_q    <= valueB[0];
                error_q     <= 1'b0;
            end
            if (state_q == S_BEGIN) cnt_q <= '0;
            if (rd_accept || wr_accept) begin
                mem_ptr_q <= mem_ptr_q + MEM_ADDR_W'(1);
                cnt_q     <= cnt_q + LEN_W'(1);
            end
            if (state_q == S_NEXT && !abort) begin
                remaining_q <= rem_next;
                bus_ptr_q   <= bus_ptr_q + (32'(len) << 2);
            end
            if (abort) error_q <= 1'b1;
        end
    end

`ifdef RAMDMA_IRQ_EN
    logic irq_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                   irq_q <= 1'b0;
        else if (abort || finish)     irq_q <= 1'b1;
        else if (ctrl_wr && valueB[2]) irq_q <= 1'b0;
    end
    assign irq     = irq_q;
    assign irq_bit = irq_q;
`else
    assign irq_bit = 1'b0;
    logic unused_finish;
    assign unused_finish = finish;
`endif

    always_comb begin
        reg_rdata = '0;
        case (ci_sel)
            3'd1:    reg_rdata = bus_addr_q;
            3'd2:    reg_rdata = 32'(mem_start_q);
            3'd3:    reg_rdata = 32'(block_q);
            3'd4:    reg_rdata = 32'(burst_q);
            3'd5:    reg_rdata = {29'd0, irq_bit, error_q, (state_q != S_IDLE)};
            default: reg_rdata = '0;
        endcase
    end

    // Writes and register reads finish in the issue cycle; memory reads one cycle later.
    assign done   = rd_pend_q || (ci_hit && (ci_wr || ci_sel != 3'd0));
    assign result = rd_pend_q ? cpu_rdata_q
                  : (ci_hit && !ci_wr && ci_sel != 3'd0) ? reg_rdata : 32'd0;

endmodule

// File: tb/tb_ramdma_ci_bidir.sv
// Self-checking bench for ramdma_ci_bidir: CI access, both DMA directions, wrap, error and reset abort.
module tb_ramdma_ci_bidir;

    typedef struct packed {
        logic [8:0]  a;
        logic [31:0] d;
    } mw_t;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        start, granted, end_transaction_in, data_valid_in, busy_in, error_in;
    logic [7:0]  ciN;
    logic [31:0] valueA, valueB, address_data_in;
    logic        done, request, read_n_write_out, begin_transaction_out;
    logic        end_transaction_out, data_valid_out;
    logic [31:0] result, address_data_out;
    logic [3:0]  byte_enables_out;
    logic [7:0]  burst_size_out;

    ramdma_ci_bidir dut (
        .clock                 (clock),
        .reset                 (rst_n),
        .start                 (start),
        .ciN                   (ciN),
        .valueA                (valueA),
        .valueB                (valueB),
        .done                  (done),
        .result                (result),
        .granted               (granted),
        .address_data_in       (address_data_in),
        .end_transaction_in    (end_transaction_in),
        .data_valid_in         (data_valid_in),
        .busy_in               (busy_in),
        .error_in              (error_in),
        .request               (request),
        .address_data_out      (address_data_out),
        .byte_enables_out      (byte_enables_out),
        .burst_size_out        (burst_size_out),
        .read_n_write_out      (read_n_write_out),
        .begin_transaction_out (begin_transaction_out),
        .end_transaction_out   (end_transaction_out),
        .data_valid_out        (data_valid_out)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model [512];
    mw_t         q_mem[$];
    logic [31:0] q_word[$];
    logic [31:0] q_baddr[$];
    logic [31:0] q_bsize[$];
    logic [8:0]  tb_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ci_drive(input logic [2:0] sel, input logic wr, input logic [8:0] addr,
                            input logic [31:0] data, input logic [7:0] id);
        valueA = {19'd0, sel, wr, addr};
        valueB = data;
        ciN    = id;
        start  = 1'b1;
    endtask

    task automatic ci_write(input logic [2:0] sel, input logic [8:0] addr, input logic [31:0] data);
        ci_drive(sel, 1'b1, addr, data, 8'd14);
        @(negedge clock);
        check("ci_wr_done", 32'(done), 32'd1);
        check("ci_wr_result", result, 32'd0);
        tick();
        start = 1'b0;
    endtask

    task automatic ci_read_reg(input logic [2:0] sel, output logic [31:0] val);
        ci_drive(sel, 1'b0, 9'd0, 32'd0, 8'd14);
        @(negedge clock);
        check("ci_rreg_done", 32'(done), 32'd1);
        val = result;
        tick();
        start = 1'b0;
    endtask

    task automatic ci_read_mem(input logic [8:0] addr, input logic [31:0] exp);
        ci_drive(3'd0, 1'b0, addr, 32'd0, 8'd14);
        @(negedge clock);
        check("ci_rmem_early", 32'(done), 32'd0);
        tick();
        start = 1'b0;
        @(negedge clock);
        check("ci_rmem_done", 32'(done), 32'd1);
        check("ci_rmem_data", result, exp);
        tick();
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_bus"}, address_data_out, 32'd0);
        check({tag, "_res"}, result, 32'd0);
        check({tag, "_ctl"}, 32'({request, begin_transaction_out, end_transaction_out, data_valid_out,
                                  read_n_write_out, done, byte_enables_out, burst_size_out}), 32'd0);
    endtask

    // Waits for request, grants for one cycle and checks the begin cycle against the scoreboard.
    task automatic grant_bus(input logic rnw);
        int t = 0;
        @(negedge clock);
        while (!request && t < 100) begin
            @(negedge clock);
            t++;
        end
        check("req_seen", 32'(request), 32'd1);
        tick();
        granted = 1'b1;
        tick();
        granted = 1'b0;
        @(negedge clock);
        check("begin_pulse", 32'(begin_transaction_out), 32'd1);
        check("req_dropped", 32'(request), 32'd0);
        check("begin_be", 32'(byte_enables_out), 32'hF);
        check("begin_rnw", 32'(read_n_write_out), 32'(rnw));
        if (q_baddr.size() == 0 || q_bsize.size() == 0) begin
            check("begin_queue", 32'd0, 32'd1);
        end else begin
            check("begin_addr", address_data_out, q_baddr.pop_front());
            check("begin_size", 32'(burst_size_out), q_bsize.pop_front());
        end
        tick();
    endtask

    task automatic rd_burst(input int len, input bit gaps);
        logic [31:0] w;
        grant_bus(1'b1);
        for (int i = 0; i < len; i++) begin
            if (gaps && (i % 3 == 1)) begin
                data_valid_in   = 1'b0;
                address_data_in = $urandom();
                tick();
            end
            w               = $urandom();
            data_valid_in   = 1'b1;
            address_data_in = w;
            model[tb_ptr]   = w;
            q_mem.push_back('{a: tb_ptr, d: w});
            tb_ptr          = tb_ptr + 9'd1;
            tick();
        end
        data_valid_in      = 1'b0;
        end_transaction_in = 1'b1;
        tick();
        end_transaction_in = 1'b0;
    endtask

    task automatic wr_burst(input int len, input int stall_at);
        int acc = 0;
        int ends = 0;
        int stalls = 0;
        int t = 0;
        grant_bus(1'b0);
        while (acc < len && t < 200) begin
            busy_in = (acc == stall_at) && (stalls < 2);
            if (busy_in) stalls++;
            @(negedge clock);
            ends += 32'(end_transaction_out);
            if (busy_in) begin
                check("wd_valid_held", 32'(data_valid_out), 32'd1);
                if (q_word.size() > 0) check("wd_hold", address_data_out, q_word[0]);
            end else if (data_valid_out) begin
                if (q_word.size() == 0) check("wd_queue", 32'd0, 32'd1);
                else check("wd_data", address_data_out, q_word.pop_front());
                acc++;
            end
            tick();
            t++;
        end
        busy_in = 1'b0;
        check("wd_count", 32'(acc), 32'(len));
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            ends += 32'(end_transaction_out);
            tick();
        end
        check("wend_once", 32'(ends), 32'd1);
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        int t = 0;
        ci_read_reg(3'd5, st);
        while (st[0] && t < 100) begin
            ci_read_reg(3'd5, st);
            t++;
        end
        check("status_idle", st, 32'd0);
    endtask

    task automatic verify_mem();
        mw_t e;
        while (q_mem.size() > 0) begin
            e = q_mem.pop_front();
            ci_read_mem(e.a, e.d);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st;
        int          acc;
        int          t;
        logic [31:0] w;

        rst_n = 1'b0; start = 1'b0; ciN = 8'd0; valueA = '0; valueB = '0;
        granted = 1'b0; address_data_in = '0; end_transaction_in = 1'b0;
        data_valid_in = 1'b0; busy_in = 1'b0; error_in = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        outputs_zero("reset");
        @(posedge clock);
        #1 rst_n = 1'b1;

        for (int s = 1; s <= 5; s++) begin
            ci_read_reg(3'(s), st);
            check("reset_reg", st, 32'd0);
        end

        // Block size 0: a start must be ignored.
        ci_write(3'd5, 9'd0, 32'd1);
        ci_read_reg(3'd5, st);
        check("zero_block_start", st, 32'd0);

        // Test 1: CI memory write/read and foreign ciN.
        ci_write(3'd0, 9'h037, 32'h57);
        model[9'h037] = 32'h57;
        ci_read_mem(9'h037, 32'h57);
        ci_drive(3'd0, 1'b1, 9'h037, 32'hDEAD_BEEF, 8'd7);
        @(negedge clock);
        check("wrong_id_done", 32'(done), 32'd0);
        check("wrong_id_result", result, 32'd0);
        tick();
        start = 1'b0;
        ci_read_mem(9'h037, 32'h57);

        // Test 2: bus-to-memory, four bursts of 8 with data_valid gaps.
        ci_write(3'd1, 9'd0, 32'h17);
        ci_write(3'd2, 9'd0, 32'h40);
        ci_write(3'd3, 9'd0, 32'd32);
        ci_write(3'd4, 9'd0, 32'd7);
        ci_read_reg(3'd3, st);
        check("cfg_block", st, 32'd32);
        foreach (q_baddr[i]) q_baddr.delete();
        for (int b = 0; b < 4; b++) begin
            q_baddr.push_back(32'h17 + 32'(b) * 32'h20);
            q_bsize.push_back(32'd7);
        end
        tb_ptr = 9'h040;
        ci_write(3'd5, 9'd0, 32'd1);
        for (int b = 0; b < 4; b++) rd_burst(8, 1'b1);
        wait_idle();
        verify_mem();

        // Test 3: memory-to-bus, 20 words as 8/8/4 with a stall; config writes while busy.
        ci_write(3'd1, 9'd0, 32'h1000);
        ci_write(3'd3, 9'd0, 32'd20);
        for (int i = 0; i < 20; i++) q_word.push_back(model[9'(64 + i)]);
        q_baddr.push_back(32'h1000); q_bsize.push_back(32'd7);
        q_baddr.push_back(32'h1020); q_bsize.push_back(32'd7);
        q_baddr.push_back(32'h1040); q_bsize.push_back(32'd3);
        ci_write(3'd5, 9'd0, 32'd2);
        ci_write(3'd1, 9'd0, 32'h9999_0000);
        ci_write(3'd5, 9'd0, 32'd1);
        ci_read_reg(3'd1, st);
        check("cfg_while_busy", st, 32'h9999_0000);
        wr_burst(8, 3);
        wr_burst(8, -1);
        wr_burst(4, 1);
        wait_idle();
        check("wr_queue_empty", 32'(q_word.size()), 32'd0);

        // Test 4: memory pointer wraps from the top of memory.
        ci_write(3'd1, 9'd0, 32'h4000);
        ci_write(3'd2, 9'd0, 32'h1FC);
        ci_write(3'd3, 9'd0, 32'd8);
        q_baddr.push_back(32'h4000); q_bsize.push_back(32'd7);
        tb_ptr = 9'h1FC;
        ci_write(3'd5, 9'd0, 32'd1);
        rd_burst(8, 1'b0);
        wait_idle();
        verify_mem();

        // Test 5: error after three words of a write burst.
        ci_write(3'd1, 9'd0, 32'h2000);
        ci_write(3'd2, 9'd0, 32'h40);
        ci_write(3'd3, 9'd0, 32'd16);
        for (int i = 0; i < 16; i++) q_word.push_back(model[9'(64 + i)]);
        q_baddr.push_back(32'h2000); q_bsize.push_back(32'd7);
        ci_write(3'd5, 9'd0, 32'd2);
        grant_bus(1'b0);
        acc = 0;
        t = 0;
        while (acc < 3 && t < 50) begin
            @(negedge clock);
            if (data_valid_out) begin
                check("err_wd", address_data_out, q_word.pop_front());
                acc++;
            end
            tick();
            t++;
        end
        check("err_words", 32'(acc), 32'd3);
        error_in = 1'b1;
        @(negedge clock);
        check("err_no_end", 32'(end_transaction_out), 32'd0);
        tick();
        error_in = 1'b0;
        @(negedge clock);
        check("err_idle_ctl", 32'({request, data_valid_out, begin_transaction_out, end_transaction_out}), 32'd0);
        tick();
        q_word.delete();
        ci_read_reg(3'd5, st);
        check("status_err", st, 32'h2);

        // Test 6: restart clears the error, then reset aborts mid-RDATA.
        ci_write(3'd1, 9'd0, 32'h3000);
        ci_write(3'd2, 9'd0, 32'h100);
        ci_write(3'd3, 9'd0, 32'd4);
        q_baddr.push_back(32'h3000); q_bsize.push_back(32'd3);
        ci_write(3'd5, 9'd0, 32'd1);
        ci_read_reg(3'd5, st);
        check("status_restart", st, 32'h1);
        grant_bus(1'b1);
        tb_ptr = 9'h100;
        for (int i = 0; i < 2; i++) begin
            w               = $urandom();
            data_valid_in   = 1'b1;
            address_data_in = w;
            q_mem.push_back('{a: tb_ptr, d: w});
            tb_ptr          = tb_ptr + 9'd1;
            tick();
        end
        data_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        outputs_zero("midreset");
        @(posedge clock);
        #1 rst_n = 1'b1;
        ci_read_reg(3'd5, st);
        check("status_after_reset", st, 32'd0);
        ci_read_reg(3'd1, st);
        check("busaddr_after_reset", st, 32'd0);
        verify_mem();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
